// File: rtl/boot_uart_tx.sv
// 8N1 UART transmitter for the boot-download link: sends the low 1..4 bytes of a
// captured 32-bit word, most significant selected byte first, each byte LSB first.
module boot_uart_tx #(
  parameter int CLK_FREQ  = 80000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word_data,
  input  logic [1:0]  word_len,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LAST_BAUD = BW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic            r_armed;
  logic [BW-1:0]   r_baud_cnt;
  logic [2:0]      r_bit_cnt;
  logic [1:0]      r_byte_cnt;
  logic [7:0]      r_shift;
  logic [23:0]     r_word;
  logic            r_tx;
  logic            r_busy;
  logic            r_done;

  logic            w_ready;
  logic            w_bit_end;
  logic [7:0]      w_first_byte;
  logic [7:0]      w_next_byte;

  // r_armed keeps word_ready low until the first edge after reset release
  assign w_ready    = (r_state == S_IDLE) && r_armed;
  assign w_bit_end  = (r_baud_cnt == LAST_BAUD);
  assign word_ready = w_ready;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign done       = r_done;

  always_comb begin
    w_first_byte = word_data[7:0];
    case (word_len)
      2'd1:    w_first_byte = word_data[15:8];
      2'd2:    w_first_byte = word_data[23:16];
      2'd3:    w_first_byte = word_data[31:24];
      default: w_first_byte = word_data[7:0];
    endcase
  end

  // Next byte is the one below the current byte_cnt; the top byte is never reloaded
  always_comb begin
    w_next_byte = r_word[7:0];
    case (r_byte_cnt)
      2'd2:    w_next_byte = r_word[15:8];
      2'd3:    w_next_byte = r_word[23:16];
      default: w_next_byte = r_word[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_word     <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (word_valid && w_ready) begin
            r_word     <= word_data[23:0];
            r_shift    <= w_first_byte;
            r_byte_cnt <= word_len;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_shift    <= {1'b0, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              r_tx      <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_byte_cnt == 2'd0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt - 1'b1;
              r_shift    <= w_next_byte;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_uart_tx.sv
// Directed bench for boot_uart_tx: a 115200-baud instance (DIV=694) and a DIV=2
// instance, checked bit by bit at the first and last clock of every UART bit.
module tb_boot_uart_tx;

  localparam int DIV  = 694;
  localparam int DIV2 = 2;

  logic        clk = 1'b0;
  logic        resetN;
  logic        wordValid, wordValid2;
  logic        wordReady, wordReady2;
  logic [31:0] wordData, wordData2;
  logic [1:0]  wordLen, wordLen2;
  logic        tx, tx2, busy, busy2, done, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boot_uart_tx #(.CLK_FREQ(80000000), .BAUD_RATE(115200)) dut (
    .clk(clk), .reset_n(resetN), .word_valid(wordValid), .word_ready(wordReady),
    .word_data(wordData), .word_len(wordLen), .tx(tx), .busy(busy), .done(done)
  );

  boot_uart_tx #(.CLK_FREQ(230400), .BAUD_RATE(115200)) dut2 (
    .clk(clk), .reset_n(resetN), .word_valid(wordValid2), .word_ready(wordReady2),
    .word_data(wordData2), .word_len(wordLen2), .tx(tx2), .busy(busy2), .done(done2)
  );

  function automatic logic txOf(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  function automatic logic busyOf(input bit sel);
    return sel ? busy2 : busy;
  endfunction

  function automatic logic doneOf(input bit sel);
    return sel ? done2 : done;
  endfunction

  function automatic logic readyOf(input bit sel);
    return sel ? wordReady2 : wordReady;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a word, waits (bounded) for acceptance and returns at frame cycle 0
  task automatic applyStimulus(input bit sel, input logic [31:0] data, input logic [1:0] len);
    int n;
    n = 0;
    if (sel) begin
      wordValid2 = 1'b1; wordData2 = data; wordLen2 = len;
    end else begin
      wordValid = 1'b1; wordData = data; wordLen = len;
    end
    while (readyOf(sel) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready before accept", readyOf(sel), 1);
    @(negedge clk);
    if (sel) wordValid2 = 1'b0;
    else wordValid = 1'b0;
  endtask

  // Expects one 10-bit frame starting at the current negedge; returns one cycle past it
  task automatic checkFrameByte(input bit sel, input int div, input logic [7:0] value, input string tag);
    logic expBit;
    for (int b = 0; b < 10; b++) begin
      expBit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : value[b-1];
      checkOutput($sformatf("%s bit%0d first", tag, b), txOf(sel), expBit);
      repeat (div - 1) @(negedge clk);
      checkOutput($sformatf("%s bit%0d last", tag, b), txOf(sel), expBit);
      checkOutput($sformatf("%s bit%0d busy", tag, b), busyOf(sel), 1);
      checkOutput($sformatf("%s bit%0d done", tag, b), doneOf(sel), 0);
      checkOutput($sformatf("%s bit%0d ready", tag, b), readyOf(sel), 0);
      @(negedge clk);
    end
  endtask

  task automatic checkWordEnd(input bit sel, input string tag);
    checkOutput({tag, " done pulse"}, doneOf(sel), 1);
    checkOutput({tag, " busy low"}, busyOf(sel), 0);
    checkOutput({tag, " ready"}, readyOf(sel), 1);
    checkOutput({tag, " idle tx"}, txOf(sel), 1);
  endtask

  initial begin
    resetN = 1'b0;
    wordValid = 1'b0; wordData = '0; wordLen = '0;
    wordValid2 = 1'b0; wordData2 = '0; wordLen2 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset tx", tx, 1);
    checkOutput("reset ready", wordReady, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("ready after release", wordReady, 1);
    checkOutput("ready2 after release", wordReady2, 1);

    $display("[TB] single byte 0x08");
    applyStimulus(1'b0, 32'h0000_0008, 2'd0);
    checkFrameByte(1'b0, DIV, 8'h08, "t1");
    checkWordEnd(1'b0, "t1");
    @(negedge clk);
    checkOutput("t1 done one cycle", done, 0);

    // Four-byte word; inputs are scrambled mid-frame, then the next word is queued with valid held
    $display("[TB] four bytes 0x6522df69 then back-to-back zero word");
    applyStimulus(1'b0, 32'h6522_df69, 2'd3);
    checkFrameByte(1'b0, DIV, 8'h65, "t2 b3");
    wordData = 32'hFFFF_FFFF;
    wordLen = 2'd0;
    checkFrameByte(1'b0, DIV, 8'h22, "t2 b2");
    checkFrameByte(1'b0, DIV, 8'hdf, "t2 b1");
    wordData = 32'h0000_0000;
    wordLen = 2'd3;
    wordValid = 1'b1;
    checkFrameByte(1'b0, DIV, 8'h69, "t2 b0");
    checkWordEnd(1'b0, "t2");
    @(negedge clk);
    wordValid = 1'b0;
    checkOutput("t3 done one cycle", done, 0);
    for (int k = 0; k < 4; k++) checkFrameByte(1'b0, DIV, 8'h00, $sformatf("t3 byte%0d", k));
    checkWordEnd(1'b0, "t3");
    @(negedge clk);

    $display("[TB] reset during data bit 4 of 0xdf");
    applyStimulus(1'b0, 32'h0000_00df, 2'd0);
    repeat (5 * DIV + 100) @(negedge clk);
    checkOutput("t5 data bit4", tx, 1);
    checkOutput("t5 busy before reset", busy, 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("t5 async tx", tx, 1);
    checkOutput("t5 async busy", busy, 0);
    checkOutput("t5 async ready", wordReady, 0);
    checkOutput("t5 async done", done, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("t5 ready after release", wordReady, 1);
    checkOutput("t5 no done", done, 0);
    applyStimulus(1'b0, 32'h0000_0069, 2'd0);
    checkFrameByte(1'b0, DIV, 8'h69, "t5 0x69");
    checkWordEnd(1'b0, "t5");

    $display("[TB] DIV=2 instance, 0x00A5 len 1");
    applyStimulus(1'b1, 32'h0000_00A5, 2'd1);
    checkFrameByte(1'b1, DIV2, 8'h00, "t6 b1");
    checkFrameByte(1'b1, DIV2, 8'hA5, "t6 b0");
    checkWordEnd(1'b1, "t6");
    @(negedge clk);
    checkOutput("t6 done one cycle", done2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
